perf_counter_bank: RTL
======================

// Module: perf_counter_bank
// PURPOSE
//  Parametrised event-counter bank; successor to the fixed per-opcode instruction counters.
//  Counts NUM_EVENTS independent 1-bit event strobes plus one enabled-cycle counter.
//  Adds a selectable overflow mode, sticky overflow flags, an atomic snapshot into shadow
//  registers, and a registered read port, so software/testbench reads are coherent.
//  Sits beside the processor decode stage; event strobes are driven by decode/branch/jump logic.
// PARAMETERS
//  NUM_EVENTS   18  number of event channels (1..64); cycle counter is extra index NUM_EVENTS
//  CNT_W        32  width of every counter and shadow register (8..64)
//  OVF_MODE     0   0 = wrap to 0 on overflow, 1 = saturate at all-ones
//  FREEZE_OVF   0   1 = any overflow stops all counting until clear
//  localparam ADDR_W = $clog2(NUM_EVENTS+1)
// PORTS
//  clk         in   1              single clock, all logic on rising edge
//  reset       in   1              synchronous, active-high
//  count_en    in   1              global count enable (events and cycle counter)
//  event_in    in   NUM_EVENTS     per-channel strobe; bit i high = +1 to counter i this cycle
//  clear       in   1              zero all live counters and overflow flags
//  snapshot    in   1              copy all live counters into shadow registers
//  rd_req      in   1              read request, sampled every cycle
//  rd_addr     in   ADDR_W         shadow index; NUM_EVENTS selects cycle counter
//  rd_valid    out  1              one-cycle pulse, rd_data/rd_err valid
//  rd_data     out  CNT_W          shadow value at rd_addr
//  rd_err      out  1              rd_addr > NUM_EVENTS; rd_data = 0
//  ovf_flags   out  NUM_EVENTS+1   sticky per-counter overflow flags
//  frozen      out  1              FREEZE_OVF=1 and some ovf_flags bit set
// BEHAVIOUR
//  - Reset: all live counters, shadows, ovf_flags, rd_data = 0; rd_valid, rd_err, frozen = 0.
//  - Increment: counter i += 1 when count_en & event_in[i] & !frozen; cycle counter when count_en & !frozen.
//    Multiple channels may increment in the same cycle; at most +1 per counter per cycle.
//  - Overflow (counter == all-ones and increment): OVF_MODE=0 -> next value 0; OVF_MODE=1 -> holds all-ones.
//    Either mode sets ovf_flags[i] on that edge. Flags are sticky until clear or reset.
//  - frozen is combinational: FREEZE_OVF & |ovf_flags. It blocks increments from the cycle after the overflow edge.
//  - Priority per counter, same edge: reset > clear > increment. Clear with an event leaves the counter at 0
//    (event dropped). Clear also zeroes ovf_flags, which releases frozen. Clear does not touch the shadows.
//  - snapshot: shadow[i] <= live value before this edge's update. Snapshot+clear on the same edge is an
//    atomic read-and-clear: shadow gets the old value, live becomes 0. Snapshot+event: shadow excludes that event.
//  - Read: rd_req at edge t gives rd_valid=1 for the cycle after t, latency 1.
//    rd_data is the shadow content before edge t's snapshot update.
//    Without rd_req, rd_valid=0 and rd_data holds its last value. Back-to-back requests are accepted every cycle.
//  - Reset mid-read: pending rd_valid is dropped (0 after reset edge).
//  - No combinational path from inputs to rd_data/rd_valid/rd_err. ovf_flags and frozen come straight from flops.
// STRUCTURE
//  - perf_pkg: ovf_mode_e {OVF_WRAP, OVF_SAT}; event index constants EV_ADD..EV_J (0..17) mapping
//    instruction classes to event_in bits; EV_CYCLE alias helper.
//  - Sub-module perf_counter_cell (params CNT_W, OVF_MODE): one live counter, its shadow,
//    and its overflow flag; inputs inc, clear, snapshot. Instantiate NUM_EVENTS+1 times via generate.
//  - Top level: freeze logic, read mux, and read output registers.
// TESTING
//  1 Reset, then count_en=1 and event_in[3] high 5 cycles, snapshot, rd_addr=3 -> rd_data=5 one cycle after rd_req.
//    Cycle counter is read with rd_addr=NUM_EVENTS.
//  2 CNT_W=8, OVF_MODE=0: 257 events on ch0 -> live=1, ovf_flags[0]=1. OVF_MODE=1: live=255, flag=1.
//  3 Snapshot and clear on the same edge with live ch2=10 and event_in[2]=1 -> shadow[2]=10, live[2]=0,
//    then 2 further events give live=2.
//  4 FREEZE_OVF=1, CNT_W=8: overflow ch1 -> frozen=1, other channels stop. Clear -> frozen=0, counting resumes.
//  5 rd_addr=NUM_EVENTS+1 -> rd_valid=1, rd_err=1, rd_data=0. Reads of addrs 0,1,2 on consecutive cycles
//    give 3 consecutive valid results.
//  6 Reset asserted for 1 cycle mid-count, with rd_req pending -> everything 0 next cycle, rd_valid=0.

Source files
------------

// File: rtl/perf_pkg.sv
// Shared types and event-channel map for the performance counter bank.
// Event indices follow the instruction classes flagged by decode.
package perf_pkg;

    typedef enum logic {
        OVF_WRAP = 1'b0,
        OVF_SAT  = 1'b1
    } ovf_mode_e;

    localparam int NUM_EV  = 18;

    localparam int EV_ADD  = 0;
    localparam int EV_SUB  = 1;
    localparam int EV_AND  = 2;
    localparam int EV_OR   = 3;
    localparam int EV_XOR  = 4;
    localparam int EV_SLL  = 5;
    localparam int EV_SRL  = 6;
    localparam int EV_SRA  = 7;
    localparam int EV_SLT  = 8;
    localparam int EV_ADDI = 9;
    localparam int EV_LW   = 10;
    localparam int EV_SW   = 11;
    localparam int EV_BEQ  = 12;
    localparam int EV_BNE  = 13;
    localparam int EV_BLT  = 14;
    localparam int EV_BGE  = 15;
    localparam int EV_JAL  = 16;
    localparam int EV_J    = 17;

    // The cycle counter always sits one past the last event channel.
    function automatic int ev_cycle(input int num_events);
        return num_events;
    endfunction

endpackage

// File: rtl/perf_counter_cell.sv
// One live counter with its shadow register and sticky overflow flag.
// Clear wins over increment; snapshot always captures the pre-edge value.
module perf_counter_cell
    import perf_pkg::*;
#(
    parameter int CNT_W    = 32,
    parameter int OVF_MODE = 0
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             inc,
    input  logic             clear,
    input  logic             snapshot,
    output logic [CNT_W-1:0] shadow,
    output logic             ovf
);

    localparam ovf_mode_e       MODE = ovf_mode_e'(OVF_MODE[0]);
    localparam logic [CNT_W-1:0] ONES = '1;

    logic [CNT_W-1:0] count;
    logic             at_max;

    assign at_max = (count == ONES);

    always_ff @(posedge clk) begin
        if (reset) begin
            count  <= '0;
            shadow <= '0;
            ovf    <= 1'b0;
        end else begin
            if (snapshot) begin
                shadow <= count;
            end
            if (clear) begin
                count <= '0;
                ovf   <= 1'b0;
            end else if (inc) begin
                if (at_max) begin
                    ovf   <= 1'b1;
                    count <= (MODE == OVF_SAT) ? ONES : '0;
                end else begin
                    count <= count + CNT_W'(1);
                end
            end
        end
    end

endmodule

// File: rtl/perf_counter_bank.sv
// Bank of event counters plus an enabled-cycle counter, with freeze-on-overflow
// and a registered read port over the shadow registers.
module perf_counter_bank
    import perf_pkg::*;
#(
    parameter  int NUM_EVENTS = 18,
    parameter  int CNT_W      = 32,
    parameter  int OVF_MODE   = 0,
    parameter  int FREEZE_OVF = 0,
    localparam int ADDR_W     = $clog2(NUM_EVENTS + 1)
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  count_en,
    input  logic [NUM_EVENTS-1:0] event_in,
    input  logic                  clear,
    input  logic                  snapshot,
    input  logic                  rd_req,
    input  logic [ADDR_W-1:0]     rd_addr,
    output logic                  rd_valid,
    output logic [CNT_W-1:0]      rd_data,
    output logic                  rd_err,
    output logic [NUM_EVENTS:0]   ovf_flags,
    output logic                  frozen
);

    localparam int N   = NUM_EVENTS + 1;
    localparam int CYC = ev_cycle(NUM_EVENTS);
    localparam logic [ADDR_W-1:0] MAX_ADDR = ADDR_W'(NUM_EVENTS);

    logic [N-1:0]     inc;
    logic [CNT_W-1:0] shadow [N];
    logic [CNT_W-1:0] rd_mux;
    logic             addr_bad;

    assign frozen = (FREEZE_OVF != 0) && (|ovf_flags);

    always_comb begin
        inc = '0;
        if (count_en && !frozen) begin
            inc[NUM_EVENTS-1:0] = event_in;
            inc[CYC]            = 1'b1;
        end
    end

    for (genvar i = 0; i < N; i++) begin : g_cell
        perf_counter_cell #(
            .CNT_W    (CNT_W),
            .OVF_MODE (OVF_MODE)
        ) u_cell (
            .clk      (clk),
            .reset    (reset),
            .inc      (inc[i]),
            .clear    (clear),
            .snapshot (snapshot),
            .shadow   (shadow[i]),
            .ovf      (ovf_flags[i])
        );
    end

    // Reads see the shadow as it was before this edge's snapshot.
    always_comb begin
        rd_mux = '0;
        for (int i = 0; i < N; i++) begin
            if (rd_addr == ADDR_W'(i)) begin
                rd_mux = shadow[i];
            end
        end
    end

    assign addr_bad = (rd_addr > MAX_ADDR);

    always_ff @(posedge clk) begin
        if (reset) begin
            rd_valid <= 1'b0;
            rd_err   <= 1'b0;
            rd_data  <= '0;
        end else begin
            rd_valid <= rd_req;
            if (rd_req) begin
                rd_err  <= addr_bad;
                rd_data <= addr_bad ? '0 : rd_mux;
            end
        end
    end

endmodule
